// File: rtl/noc_inj_pkg.sv
// Shared definitions for the endpoint flit injector: FSM state type and
// flit / head-payload field offsets.
package noc_inj_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } inj_state_e;

    // Offsets for the default configuration (V=2, Fpay=32, EAw=4).
    localparam int DEF_V    = 2;
    localparam int DEF_FPAY = 32;
    localparam int DEF_EAW  = 4;

    localparam int HEAD_BIT = DEF_V + DEF_FPAY + 1;
    localparam int TAIL_BIT = DEF_V + DEF_FPAY;
    localparam int VC_LSB   = DEF_FPAY;

    localparam int HEAD_DEST_LSB = 0;
    localparam int HEAD_SRC_LSB  = DEF_EAW;
    localparam int HEAD_LEN_LSB  = 2 * DEF_EAW;

    // Parameterised forms used by the RTL so other widths stay consistent.
    function automatic int head_bit_of(input int v, input int fpay);
        return v + fpay + 1;
    endfunction

    function automatic int tail_bit_of(input int v, input int fpay);
        return v + fpay;
    endfunction

    function automatic int head_src_lsb(input int eaw);
        return eaw;
    endfunction

    function automatic int head_len_lsb(input int eaw);
        return 2 * eaw;
    endfunction

endpackage

// File: rtl/inj_credit_counter.sv
// Per-VC credit counter: starts at B, decrements on send, increments on
// credit return, and saturates at both ends.
module inj_credit_counter #(
    parameter int B  = 4,
    parameter int CW = $clog2(B + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dec,
    input  logic          inc,
    output logic          has_credit,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= CW'(B);
        end else if (dec && !inc) begin
            if (count != '0) count <= count - CW'(1);
        end else if (inc && !dec) begin
            if (count != CW'(B)) count <= count + CW'(1);
        end
    end

    assign has_credit = (count != '0);

    // A send with no credit or a return beyond B means the link is broken.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(dec && !inc && count == '0));
            assert (!(inc && !dec && count == CW'(B)));
        end
    end

endmodule

// File: rtl/ni_flit_injector.sv
// Packet-to-flit injector with round-robin VC allocation and credit flow
// control. Define NI_INJECTOR_STAT_EN to add packet/flit/stall counters.
module ni_flit_injector
    import noc_inj_pkg::*;
#(
    parameter int V        = 2,
    parameter int Fpay     = 32,
    parameter int B        = 4,
    parameter int EAw      = 4,
    parameter int LENw     = 5,
    parameter int SRC_ADDR = 0,
    localparam int Fw      = 2 + V + Fpay,
    localparam int CW      = $clog2(B + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            pck_req_valid,
    output logic            pck_req_ready,
    input  logic [EAw-1:0]  pck_dest,
    input  logic [LENw-1:0] pck_len,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_wr,
    input  logic [V-1:0]    credit_in,
    output logic            busy,
    output inj_state_e      dbg_state,
    output logic            dbg_started,
    output logic [V*CW-1:0] dbg_credit
`ifdef NI_INJECTOR_STAT_EN
    ,
    output logic [31:0]     stat_pck_cnt,
    output logic [31:0]     stat_flit_cnt,
    output logic [31:0]     stat_stall_cnt
`endif
);

    localparam int RRW     = (V > 1) ? $clog2(V) : 1;
    localparam int TAIL_B  = tail_bit_of(V, Fpay);
    localparam int SRC_LSB = head_src_lsb(EAw);
    localparam int LEN_LSB = head_len_lsb(EAw);

    inj_state_e      state;
    logic            started;
    logic [RRW-1:0]  rr_ptr;
    logic [V-1:0]    vc_q;
    logic [LENw-1:0] len_q;
    logic [LENw-1:0] idx_q;

    logic [V-1:0]    has_credit;
    logic [V-1:0]    dec;
    logic [V-1:0]    pick;
    logic [RRW-1:0]  pick_idx;
    logic [RRW-1:0]  rr_next;
    logic [RRW-1:0]  cand;
    logic            found;
    logic            accept;
    logic            send_now;
    logic            last;
    logic [Fpay-1:0] head_pay;

    for (genvar v = 0; v < V; v++) begin : g_vc
        inj_credit_counter #(.B(B), .CW(CW)) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .dec        (dec[v]),
            .inc        (credit_in[v]),
            .has_credit (has_credit[v]),
            .count      (dbg_credit[v*CW +: CW])
        );
    end

    // Round-robin search from rr_ptr over VCs that currently hold credit.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = '0;
        for (int i = 0; i < V; i++) begin
            cand = RRW'((int'(rr_ptr) + i) % V);
            if (!found && has_credit[cand]) begin
                found       = 1'b1;
                pick[cand]  = 1'b1;
                pick_idx    = cand;
            end
        end
    end

    assign rr_next = (pick_idx == RRW'(V - 1)) ? '0 : pick_idx + RRW'(1);

    // Handshake: a request transfers on any cycle pck_req_valid and
    // pck_req_ready are both high; ready never waits on valid's history.
    assign accept   = (state == IDLE) && started && pck_req_valid
                      && (pck_len != '0) && found;
    assign send_now = (state == SEND) && |(vc_q & has_credit);
    assign last     = (idx_q == len_q - LENw'(1));
    assign dec      = accept ? pick : (send_now ? vc_q : '0);

    always_comb begin
        head_pay                   = '0;
        head_pay[EAw-1:0]          = pck_dest;
        head_pay[SRC_LSB +: EAw]   = EAw'(SRC_ADDR);
        head_pay[LEN_LSB +: LENw]  = pck_len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            started     <= 1'b0;
            rr_ptr      <= '0;
            vc_q        <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            flit_out    <= '0;
            flit_out_wr <= 1'b0;
        end else begin
            if (start_i) started <= 1'b1;
            flit_out_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        flit_out    <= {1'b1, (pck_len == LENw'(1)), pick, head_pay};
                        flit_out_wr <= 1'b1;
                        vc_q        <= pick;
                        len_q       <= pck_len;
                        idx_q       <= LENw'(1);
                        rr_ptr      <= rr_next;
                        if (pck_len != LENw'(1)) state <= SEND;
                    end
                end
                SEND: begin
                    if (send_now) begin
                        flit_out    <= {1'b0, last, vc_q, Fpay'(idx_q)};
                        flit_out_wr <= 1'b1;
                        idx_q       <= idx_q + LENw'(1);
                        if (last) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The FSM leaves SEND as the tail is registered, so the visible tail
    // cycle overlaps IDLE and can accept the next request with no bubble.
    assign pck_req_ready = accept;
    assign busy          = accept || (state == SEND) || (flit_out_wr && flit_out[TAIL_B]);
    assign dbg_state     = state;
    assign dbg_started   = started;

`ifdef NI_INJECTOR_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_pck_cnt   <= '0;
            stat_flit_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (accept || send_now) stat_flit_cnt <= stat_flit_cnt + 32'd1;
            if ((accept && pck_len == LENw'(1)) || (send_now && last))
                stat_pck_cnt <= stat_pck_cnt + 32'd1;
            if (state == SEND && !send_now) stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
